// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and store-formatting helpers for the load/store unit
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BUS   = 2'b01,
    DONE  = 2'b10,
    FAULT = 2'b11
  } lsu_state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  function automatic logic [3:0] store_strb(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_B:    return 4'b0001 << lane;
      SZ_H:    return 4'b0011 << lane;
      SZ_W:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Replicating across lanes lets the bus pick the byte/half with wstrb alone.
  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SZ_B:    return {4{wdata[7:0]}};
      SZ_H:    return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  function automatic logic req_bad(input logic [1:0] size, input logic [1:0] lane);
    return (size == 2'b11) || (size == SZ_H && lane[0]) || (size == SZ_W && lane != 2'b00);
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// rtl/lsu_load_extend.sv - selects the addressed load field and sign/zero extends it
import lsu_pkg::*;

module lsu_load_extend (
  input  logic [31:0] rdata_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] ext_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata_i >> {lane_i, 3'b000};
    case (size_i)
      SZ_B:    ext_o = unsigned_i ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      SZ_H:    ext_o = unsigned_i ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: ext_o = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store responder between execute and data memory
import lsu_pkg::*;

module load_store_unit #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TO_W           = 5
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_memReq,
  input  logic            i_memWrite,
  input  logic            i_isLoadSigned,
  input  logic [1:0]      i_size,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_wdata,
  output logic            o_stall,
  output logic            o_done,
  output logic            o_fault,
  output logic [XLEN-1:0] o_rdata,
  output logic            o_busReq,
  output logic            o_busWe,
  output logic [XLEN-1:0] o_busAddr,
  output logic [3:0]      o_busWstrb,
  output logic [XLEN-1:0] o_busWdata,
  input  logic            i_busAck,
  input  logic [XLEN-1:0] i_busRdata
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);

  lsu_state_t      state_q, state_d;
  logic [TO_W-1:0] count_q, count_d;
  logic [XLEN-1:0] rdata_q, addr_q, wdata_q;
  logic [3:0]      wstrb_q;
  logic            we_q, unsigned_q;
  logic [1:0]      size_q, lane_q;
  logic [31:0]     ext_data;
  logic            bad_req, timeout_hit;

  assign bad_req     = req_bad(i_size, i_addr[1:0]);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (count_q == TO_LAST);

  lsu_load_extend u_ext (
    .rdata_i    (i_busRdata),
    .lane_i     (lane_q),
    .size_i     (size_q),
    .unsigned_i (unsigned_q),
    .ext_o      (ext_data)
  );

  always_comb begin
    state_d = state_q;
    count_d = '0;
    o_stall = 1'b0;
    case (state_q)
      IDLE: begin
        o_stall = i_memReq;
        if (i_memReq) state_d = bad_req ? FAULT : BUS;
      end
      BUS: begin
        o_stall = 1'b1;
        count_d = count_q + TO_W'(1);
        // Ack is checked first so a same-cycle ack beats the timeout.
        if (i_busAck)         state_d = DONE;
        else if (timeout_hit) state_d = FAULT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      rdata_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      we_q       <= 1'b0;
      unsigned_q <= 1'b0;
      size_q     <= SZ_B;
      lane_q     <= 2'b00;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (state_q == IDLE && i_memReq) begin
        rdata_q <= '0;
        // Faulting requests leave the bus registers untouched: no bus activity.
        if (!bad_req) begin
          addr_q     <= {i_addr[XLEN-1:2], 2'b00};
          we_q       <= i_memWrite;
          wstrb_q    <= i_memWrite ? store_strb(i_size, i_addr[1:0]) : 4'b0000;
          wdata_q    <= i_memWrite ? store_data(i_size, i_wdata) : '0;
          size_q     <= i_size;
          lane_q     <= i_addr[1:0];
          unsigned_q <= i_isLoadSigned;
        end
      end
      if (state_q == BUS && i_busAck) rdata_q <= we_q ? '0 : ext_data;
    end
  end

  assign o_busReq   = (state_q == BUS);
  assign o_done     = (state_q == DONE) || (state_q == FAULT);
  assign o_fault    = (state_q == FAULT);
  assign o_rdata    = rdata_q;
  assign o_busAddr  = addr_q;
  assign o_busWe    = we_q;
  assign o_busWstrb = wstrb_q;
  assign o_busWdata = wdata_q;

endmodule
